// File: rtl/jbi_snp_req_xmit.sv
`default_nettype none
// ============================================================================
// Module   : jbi_snp_req_xmit
// Purpose  : JBI-side request transmitter feeding the sctag snoop IQ. It
//            accepts one read/WR8/WR64 request at a time, pulses jbi_req_vld
//            and then serializes the header and data beats onto the 32-bit
//            jbi_sctag_req bus. A credit counter tracks the free snoop IQ
//            entries and is refilled by sctag_jbi_iq_dequeue.
// Options  : JBI_SNP_XMIT_STALL_CNT_EN adds a saturating stall_cnt output
//            counting cycles in which a request waits in IDLE for a credit.
// Revision : 1.0 - initial release
// ============================================================================
module jbi_snp_req_xmit #(
  parameter int CREDITS = 2,
  parameter int CRW     = 2
) (
  input  logic           rclk,
  input  logic           rst,
  input  logic           src_vld,
  output logic           src_rdy,
  input  logic           src_wr64,
  input  logic [63:0]    src_hdr,
  input  logic [63:0]    src_data,
  output logic [3:0]     src_widx,
  output logic           src_wrd,
  input  logic [31:0]    src_wdata,
  output logic           jbi_req_vld,
  output logic [31:0]    jbi_sctag_req,
  input  logic           sctag_jbi_iq_dequeue,
  output logic [CRW-1:0] credit_cnt,
  output logic           busy,
  output logic           cred_err
`ifdef JBI_SNP_XMIT_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  localparam logic [CRW-1:0] c_cred_full = CRW'(CREDITS);
  localparam logic [CRW-1:0] c_cred_one  = CRW'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HDR1 = 3'd2,
    ST_HDR2 = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  state_t         state_q;
  logic [63:0]    hdr_q;
  logic [63:0]    data_q;
  logic           wr64_q;
  logic           beat_q;      // short request: 0 while data1 is on the bus
  logic           vld_q;
  logic [31:0]    bus_q;
  logic           wrd_q;
  logic [3:0]     widx_q;
  logic [CRW-1:0] credit_q;
  logic [CRW-1:0] credit_d;
  logic           err_q;
  logic           err_d;
  logic           w_accept;

  assign w_accept      = ~rst & (state_q == ST_IDLE) & (credit_q != '0) & src_vld;
  assign src_rdy       = w_accept;
  assign busy          = (state_q != ST_IDLE);
  assign jbi_req_vld   = vld_q;
  assign jbi_sctag_req = bus_q;
  assign src_wrd       = wrd_q;
  assign src_widx      = widx_q;
  assign credit_cnt    = credit_q;
  assign cred_err      = err_q;

  // Request sequencer: every bus/fetch output is registered one cycle ahead.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      data_q  <= '0;
      wr64_q  <= 1'b0;
      beat_q  <= 1'b0;
      vld_q   <= 1'b0;
      bus_q   <= '0;
      wrd_q   <= 1'b0;
      widx_q  <= '0;
    end else begin
      // WR64 fetch index walks 0..15, then drops src_wrd and wraps to 0.
      if (wrd_q) begin
        if (widx_q == 4'hF) wrd_q <= 1'b0;
        widx_q <= widx_q + 4'd1;
      end
      case (state_q)
        ST_IDLE: begin
          bus_q <= '0;
          vld_q <= 1'b0;
          if (w_accept) begin
            hdr_q   <= src_hdr;
            data_q  <= src_data;
            wr64_q  <= src_wr64;
            vld_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          vld_q   <= 1'b0;
          bus_q   <= hdr_q[63:32];
          state_q <= ST_HDR1;
        end
        ST_HDR1: begin
          bus_q <= hdr_q[31:0];
          if (wr64_q) begin
            wrd_q  <= 1'b1;
            widx_q <= 4'h0;
          end
          state_q <= ST_HDR2;
        end
        ST_HDR2: begin
          bus_q   <= wr64_q ? src_wdata : data_q[63:32];
          beat_q  <= 1'b0;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (wr64_q) begin
            // src_wrd stays high until the last word has been fetched.
            if (wrd_q) begin
              bus_q <= src_wdata;
            end else begin
              bus_q   <= '0;
              state_q <= ST_IDLE;
            end
          end else if (!beat_q) begin
            bus_q  <= data_q[31:0];
            beat_q <= 1'b1;
          end else begin
            bus_q   <= '0;
            beat_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          bus_q   <= '0;
          vld_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Credit next-state: accept consumes, dequeue returns, both cancel out.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (w_accept && !sctag_jbi_iq_dequeue) begin
      credit_d = credit_q - c_cred_one;
    end else if (!w_accept && sctag_jbi_iq_dequeue) begin
      if (credit_q == c_cred_full) err_d = 1'b1;
      else credit_d = credit_q + c_cred_one;
    end
  end

  // Credit counter and sticky over-dequeue flag.
  always_ff @(posedge rclk) begin
    if (rst) begin
      credit_q <= c_cred_full;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

`ifdef JBI_SNP_XMIT_STALL_CNT_EN
  logic [15:0] stall_q;
  assign stall_cnt = stall_q;

  // Saturating count of cycles a pending request is blocked by zero credit.
  always_ff @(posedge rclk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (src_vld && (state_q == ST_IDLE) && (credit_q == '0) &&
                 (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_jbi_snp_req_xmit.sv
`default_nettype none
// ============================================================================
// Module   : tb_jbi_snp_req_xmit
// Purpose  : Directed scoreboard bench for jbi_snp_req_xmit. Expected bus
//            beats, vld pulses and WR64 fetch indices are queued with their
//            cycle stamp at accept time and checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jbi_snp_req_xmit;

  typedef struct packed {
    int          cyc;
    logic [31:0] val;
  } ent_t;

  logic        rclk = 1'b0;
  logic        rst = 1'b1;
  logic        src_vld = 1'b0;
  logic        src_wr64 = 1'b0;
  logic [63:0] src_hdr = '0;
  logic [63:0] src_data = '0;
  logic        deq = 1'b0;
  logic        src_rdy;
  logic [3:0]  src_widx;
  logic        src_wrd;
  logic [31:0] src_wdata;
  logic        jbi_req_vld;
  logic [31:0] jbi_sctag_req;
  logic [1:0]  credit_cnt;
  logic        busy;
  logic        cred_err;
`ifdef JBI_SNP_XMIT_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  ent_t bq[$];
  ent_t vq[$];
  ent_t wq[$];

  jbi_snp_req_xmit #(.CREDITS(2), .CRW(2)) dut (
    .rclk                 (rclk),
    .rst                  (rst),
    .src_vld              (src_vld),
    .src_rdy              (src_rdy),
    .src_wr64             (src_wr64),
    .src_hdr              (src_hdr),
    .src_data             (src_data),
    .src_widx             (src_widx),
    .src_wrd              (src_wrd),
    .src_wdata            (src_wdata),
    .jbi_req_vld          (jbi_req_vld),
    .jbi_sctag_req        (jbi_sctag_req),
    .sctag_jbi_iq_dequeue (deq),
    .credit_cnt           (credit_cnt),
    .busy                 (busy),
    .cred_err             (cred_err)
`ifdef JBI_SNP_XMIT_STALL_CNT_EN
    ,
    .stall_cnt            (stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc <= cyc + 1;

  // WR64 source: word k is k replicated into every byte.
  assign src_wdata = {4{4'h0, src_widx}};

  // Per-cycle scoreboard check of bus, vld and WR64 fetch strobe.
  always @(negedge rclk) begin
    ent_t        e;
    logic [31:0] eb;
    logic        ev;
    logic [4:0]  ew;
    if (mon_en) begin
      eb = '0;
      ev = 1'b0;
      ew = '0;
      if (bq.size() > 0 && bq[0].cyc == cyc) begin e = bq.pop_front(); eb = e.val; end
      if (vq.size() > 0 && vq[0].cyc == cyc) begin e = vq.pop_front(); ev = 1'b1; end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin e = wq.pop_front(); ew = {1'b1, e.val[3:0]}; end
      n_chk++;
      assert (jbi_sctag_req === eb) else begin
        n_fail++;
        $error("FAIL bus cyc=%0d observed=%h expected=%h", cyc, jbi_sctag_req, eb);
      end
      n_chk++;
      assert (jbi_req_vld === ev) else begin
        n_fail++;
        $error("FAIL req_vld cyc=%0d observed=%b expected=%b", cyc, jbi_req_vld, ev);
      end
      n_chk++;
      if (ew[4]) begin
        assert ({src_wrd, src_widx} === ew) else begin
          n_fail++;
          $error("FAIL widx cyc=%0d observed=%b/%h expected=1/%h", cyc, src_wrd, src_widx, ew[3:0]);
        end
      end else begin
        assert (src_wrd === 1'b0) else begin
          n_fail++;
          $error("FAIL wrd_idle cyc=%0d observed=%b expected=0", cyc, src_wrd);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push_exp(input int a);
    vq.push_back('{a + 1, 32'd1});
    bq.push_back('{a + 2, src_hdr[63:32]});
    bq.push_back('{a + 3, src_hdr[31:0]});
    if (src_wr64) begin
      for (int k = 0; k < 16; k++) begin
        wq.push_back('{a + 3 + k, 32'(k)});
        bq.push_back('{a + 4 + k, 32'(k) * 32'h01010101});
      end
    end else begin
      bq.push_back('{a + 4, src_data[63:32]});
      bq.push_back('{a + 5, src_data[31:0]});
    end
  endtask

  // Called with inputs already driven; returns in cycle a+1.
  task automatic wait_acc(input int maxc, output int a);
    a = -1;
    for (int i = 0; i < maxc; i++) begin
      #1;
      if (src_rdy === 1'b1) begin
        a = cyc;
        break;
      end
      @(posedge rclk);
      #1;
    end
    n_chk++;
    assert (a >= 0) else begin
      n_fail++;
      $error("FAIL accept_timeout observed=none expected=accept within %0d cycles", maxc);
    end
    if (a >= 0) begin
      push_exp(a);
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (busy === 1'b0) break;
      tick(1);
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic dequeue();
    deq = 1'b1;
    tick(1);
    deq = 1'b0;
  endtask

  task automatic drop_after(input int c);
    while (bq.size() > 0 && bq[bq.size() - 1].cyc > c) void'(bq.pop_back());
    while (vq.size() > 0 && vq[vq.size() - 1].cyc > c) void'(vq.pop_back());
    while (wq.size() > 0 && wq[wq.size() - 1].cyc > c) void'(wq.pop_back());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int a1;
    int a2;
    int a3;

    // Reset state
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_credit", 32'(credit_cnt), 32'd2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cred_err), 32'd0);
    chk("rst_rdy", 32'(src_rdy), 32'd0);
    tick(2);

    // Short request
    src_hdr = 64'h11112222_33334444;
    src_data = 64'hAAAABBBB_CCCCDDDD;
    src_wr64 = 1'b0;
    src_vld = 1'b1;
    wait_acc(1, a);
    src_vld = 1'b0;
    chk("short_credit", 32'(credit_cnt), 32'd1);
    wait_idle(10);
    chk("short_idle_cyc", 32'(cyc), 32'(a + 6));
    dequeue();
    chk("short_deq_credit", 32'(credit_cnt), 32'd2);

    // WR64 request
    src_hdr = 64'hDEAD0001_BEEF0002;
    src_wr64 = 1'b1;
    src_vld = 1'b1;
    wait_acc(1, a);
    src_vld = 1'b0;
    wait_idle(25);
    chk("wr64_idle_cyc", 32'(cyc), 32'(a + 20));
    dequeue();
    chk("wr64_deq_credit", 32'(credit_cnt), 32'd2);

    // Three back-to-back short requests, no dequeue
    src_wr64 = 1'b0;
    src_hdr = 64'h00000001_00000011;
    src_data = 64'h00000101_00001001;
    src_vld = 1'b1;
    wait_acc(1, a1);
    src_hdr = 64'h00000002_00000022;
    src_data = 64'h00000202_00002002;
    wait_acc(12, a2);
    chk("b2b_spacing", 32'(a2 - a1), 32'd6);
    src_hdr = 64'h00000003_00000033;
    src_data = 64'h00000303_00003003;
    tick(5);
    #1;
    chk("b2b_held_rdy", 32'(src_rdy), 32'd0);
    chk("b2b_held_credit", 32'(credit_cnt), 32'd0);
    chk("b2b_held_busy", 32'(busy), 32'd0);
    tick(2);
    #1;
    chk("b2b_held_rdy2", 32'(src_rdy), 32'd0);
    dequeue();
    chk("b2b_deq_credit", 32'(credit_cnt), 32'd1);
    wait_acc(1, a3);
    src_vld = 1'b0;
    chk("b2b_third_cyc", 32'(a3), 32'(a2 + 9));
    wait_idle(10);
    chk("b2b_end_credit", 32'(credit_cnt), 32'd0);

    // Accept and dequeue in the same cycle at credit 1
    dequeue();
    src_hdr = 64'h0A0B0C0D_01020304;
    src_data = 64'h55556666_77778888;
    src_vld = 1'b1;
    deq = 1'b1;
    wait_acc(1, a);
    deq = 1'b0;
    src_vld = 1'b0;
    chk("same_cycle_credit", 32'(credit_cnt), 32'd1);
    wait_idle(10);
    dequeue();
    chk("refill_credit", 32'(credit_cnt), 32'd2);

    // Extra dequeue at full credit
    dequeue();
    chk("over_deq_credit", 32'(credit_cnt), 32'd2);
    chk("over_deq_err", 32'(cred_err), 32'd1);
    tick(3);
    chk("err_sticky", 32'(cred_err), 32'd1);

    // Reset during beat 7 of a WR64
    src_hdr = 64'hCAFE0000_F00D0000;
    src_wr64 = 1'b1;
    src_vld = 1'b1;
    wait_acc(1, a);
    src_vld = 1'b0;
    tick(10);
    chk("pre_rst_cyc", 32'(cyc), 32'(a + 11));
    chk("pre_rst_credit", 32'(credit_cnt), 32'd1);
    drop_after(cyc);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bus", jbi_sctag_req, 32'd0);
    chk("abort_vld", 32'(jbi_req_vld), 32'd0);
    chk("abort_credit", 32'(credit_cnt), 32'd2);
    chk("abort_err", 32'(cred_err), 32'd0);
    tick(3);
    chk("abort_quiet_bus", jbi_sctag_req, 32'd0);

`ifdef JBI_SNP_XMIT_STALL_CNT_EN
    // Stall counter at zero credit
    src_wr64 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      src_hdr = {32'h5700_0000 + 32'(r), 32'h0000_5700};
      src_data = {32'h5800_0000 + 32'(r), 32'h0000_5800};
      src_vld = 1'b1;
      wait_acc(1, a);
      src_vld = 1'b0;
      wait_idle(10);
    end
    chk("stall_start", 32'(stall_cnt), 32'd0);
    src_vld = 1'b1;
    tick(10);
    src_vld = 1'b0;
    chk("stall_cnt", 32'(stall_cnt), 32'd10);
    tick(2);
    chk("stall_hold", 32'(stall_cnt), 32'd10);
    dequeue();
    dequeue();
`endif

    tick(3);
    chk("sb_bus_empty", 32'(bq.size()), 32'd0);
    chk("sb_vld_empty", 32'(vq.size()), 32'd0);
    chk("sb_widx_empty", 32'(wq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jbi_snp_req_xmit.md
Name: jbi_snp_req_xmit

Overview:
JBI-side transmitter that sits directly upstream of the sctag snoop input queue. It accepts one request at a time from the JBI request source (read, WR8 or WR64). It pulses jbi_req_vld, then serializes the header and data onto the 32-bit jbi_sctag_req bus in the beat order and spacing the snoop IQ expects. It tracks the 2-entry snoop IQ with a credit counter that is replenished by sctag_jbi_iq_dequeue.

Parameters:
CREDITS, 2, number of sctag snoop IQ entries; reset value of the credit counter
CRW, 2, credit counter width; must hold CREDITS

Ports:
rclk  in  1  clock
rst  in  1  reset, synchronous, active-high
src_vld  in  1  source has a request
src_rdy  out  1  request accepted this cycle
src_wr64  in  1  request is WR64 (16 data beats); otherwise 2 data beats
src_hdr  in  64  header; hdr1=[63:32], hdr2=[31:0]; passed unmodified
src_data  in  64  short data; data1=[63:32], data2=[31:0]
src_widx  out  4  WR64 beat index being fetched
src_wrd  out  1  src_widx valid; src_wdata sampled this cycle
src_wdata  in  32  WR64 data word for src_widx (combinational from source)
jbi_req_vld  out  1  one-cycle request pulse to sctag
jbi_sctag_req  out  32  registered beat bus to sctag
sctag_jbi_iq_dequeue  in  1  sctag retired one IQ entry
credit_cnt  out  CRW  available IQ entries
busy  out  1  state != IDLE
cred_err  out  1  sticky; dequeue seen while credit_cnt==CREDITS

Behaviour:
- Reset values: state IDLE, credit_cnt=CREDITS, jbi_req_vld=0, jbi_sctag_req=0, src_rdy=0, src_wrd=0, src_widx=0, cred_err=0. Reset mid-transfer aborts the transfer immediately with no further beats.
- src_rdy = (state==IDLE) & (credit_cnt!=0) & src_vld. Accept = src_rdy.
- On accept, src_hdr, src_data and src_wr64 are latched.
- States: IDLE -> REQ -> HDR1 -> HDR2 -> DATA -> IDLE.
- Timeline for a request accepted in cycle A:
  - A+1 (REQ): jbi_req_vld=1.
  - A+2: bus=hdr1.
  - A+3: bus=hdr2.
  - Short request: A+4 bus=data1; A+5 bus=data2; IDLE at A+6.
  - WR64: bus carries beat k (k=0..15) in cycle A+4+k; IDLE at A+20.
- WR64 fetch: src_wrd=1 and src_widx=k in cycle A+3+k. src_wdata is registered onto the bus the following cycle.
- Bus is 0 in every non-beat cycle. jbi_req_vld is high only in REQ.
- Minimum spacing between jbi_req_vld pulses: 6 cycles after a short request, 20 after a WR64. This meets the sctag requirement of >=5 and >=19.
- Credit arithmetic:
  - Accept alone: credit-1.
  - Dequeue alone: credit+1.
  - Accept and dequeue in the same cycle: credit unchanged.
  - credit_cnt updates on the next edge.
  - Dequeue at credit_cnt==CREDITS (with no simultaneous accept): count holds and cred_err sets. cred_err clears only on rst.
  - Accept is impossible at credit 0, so the count never underflows.
- src_vld deasserted while not in IDLE is ignored. The latched request completes regardless.
- Dequeue is accepted in any state.

Optional Feature:
JBI_SNP_XMIT_STALL_CNT_EN:
- Defined: adds output stall_cnt[15:0]. It increments each cycle with src_vld & (state==IDLE) & (credit_cnt==0), saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: no stall_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then a short request with hdr=64'h11112222_33334444 and data=64'hAAAABBBB_CCCCDDDD accepted at cycle A -> vld at A+1; bus 11112222, 33334444, AAAABBBB, CCCCDDDD at A+2..A+5; credit_cnt 2->1.
- WR64 with src_wdata=widx*0x01010101 -> src_widx 0..15 at A+3..A+18; bus beats 00000000..0F0F0F0F at A+4..A+19; IDLE at A+20.
- Three back-to-back short requests with no dequeue -> two issue with vld pulses 6 cycles apart; third held with src_rdy=0 and credit_cnt=0; dequeue -> third accepted the next cycle.
- Dequeue in the same cycle as an accept at credit_cnt=1 -> credit_cnt stays 1.
- Extra dequeue at credit_cnt=2 -> credit_cnt stays 2 and cred_err=1 until rst.
- rst asserted at beat 7 of a WR64 -> next cycle bus=0, vld=0, state IDLE, credit_cnt=2. With the macro defined: 10 blocked cycles at credit 0 -> stall_cnt=10.
